// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Build option UART_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module uart_tx_arb #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]       tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic [ID_W-1:0]         grant_id,
   output logic                    grant_valid
);

   // state       | meaning
   // S_IDLE      | free; grant the next valid requester when the transmitter is idle
   // S_START     | tx_start strobe is high, byte is stable on tx_data
   // S_WAIT_BUSY | waiting up to BUSY_TMO cycles for the transmitter to raise tx_busy
   // S_WAIT_DONE | frame in progress, waiting for tx_busy to fall
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;

   localparam int BUSY_TMO = 2;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [1:0]        tmo_q, tmo_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;
   logic [ID_W-1:0]   grant_id_q, grant_id_d;
   logic              grant_valid_q, grant_valid_d;

   logic [ID_W-1:0]   search_base;
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   win_id;
   logic              win_found;

`ifdef UART_ARB_FIXED_PRIO_EN
   assign search_base = '0;
`else
   assign search_base = ptr_q;
`endif

   // N_REQ is a power of two, so the ID_W-bit add wraps the search modulo N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = search_base + ID_W'(k);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      tmo_d         = tmo_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      req_ready     = '0;
      case (state_q)
         S_IDLE: begin
            if (win_found && !tx_busy && !rst) begin
               req_ready     = N_REQ'(1) << win_id;
               tx_data_d     = req_data[int'(win_id)*DATA_W +: DATA_W];
               tx_start_d    = 1'b1;
               grant_id_d    = win_id;
               grant_valid_d = 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
               ptr_d         = '0;
`else
               ptr_d         = win_id + ID_W'(1);
`endif
               state_d       = S_START;
            end
         end
         S_START: begin
            tmo_d   = 2'(BUSY_TMO - 1);
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_q == '0) begin
               state_d       = S_IDLE;
               grant_valid_d = 1'b0;
            end else begin
               tmo_d = tmo_q - 2'd1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               state_d       = S_IDLE;
               grant_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         tmo_q         <= '0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         tmo_q         <= tmo_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign grant_id    = grant_id_q;
   assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a transaction-level model.
// The model predicts winner, accept cycle and release cycle from the arbitration and timing rules.
module tb_uart_tx_arb;
   localparam int N   = 4;
   localparam int DW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic [DW-1:0] tx_data;
   logic          tx_start;
   logic          tx_busy;
   logic [1:0]    grant_id;
   logic          grant_valid;

   uart_tx_arb #(.N_REQ(N), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .grant_id(grant_id), .grant_valid(grant_valid)
   );

   always #5 clk = ~clk;

   typedef enum {M_HOLD, M_ALL, M_RAND} mode_t;

   mode_t         mode;
   logic [N-1:0]  v;
   logic [DW-1:0] d [N];
   int            rem [N];
   logic [N-1:0]  hs_prev;
   int            cyc, rst_at, ext_left;
   int            busy_lo, busy_hi, fl, fd;
   int            t0, avail, exp_ptr, exp_gid, n_acc, dut_acc_cyc;
   logic [DW-1:0] exp_data;
   int            dlog[$];
   int            dstart[$];
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic int pick(logic [N-1:0] vv, int p);
      for (int k = 0; k < N; k++)
         if (vv[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // One clock cycle: drive inputs after the edge, then compare against the model.
   task automatic step();
      logic [N-1:0] want_ready;
      int w;
      @(posedge clk);
      #1;
      cyc++;
      rst = (cyc == rst_at);
      for (int i = 0; i < N; i++) begin
         if (hs_prev[i]) begin
            v[i] = 1'b0;
            if (rem[i] > 0) rem[i]--;
         end
         if (mode == M_ALL) begin
            if (!v[i] && rem[i] > 0) begin
               v[i] = 1'b1;
               d[i] = DW'($urandom);
            end
         end else if (mode == M_RAND) begin
            if (!v[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  v[i] = 1'b1;
                  d[i] = DW'($urandom);
               end
            end else if ($urandom_range(0, 15) == 0) begin
               v[i] = 1'b0;
            end
         end
      end
      if (mode == M_RAND && ext_left == 0 && cyc >= avail && cyc > busy_hi &&
          $urandom_range(0, 19) == 0)
         ext_left = $urandom_range(1, 4);
      tx_busy = (cyc >= busy_lo && cyc <= busy_hi) || ext_left > 0;
      if (ext_left > 0) ext_left--;
      req_valid = v;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
      #1;
      want_ready = '0;
      w = -1;
      if (cyc >= avail && !tx_busy && !rst && v != '0) begin
`ifdef UART_ARB_FIXED_PRIO_EN
         w = pick(v, 0);
`else
         w = pick(v, exp_ptr);
`endif
         want_ready = N'(1) << w;
      end
      check("req_ready", req_ready, want_ready);
      check("tx_start", tx_start, cyc == t0 + 1);
      check("grant_valid", grant_valid, t0 >= 0 && cyc > t0 && cyc < avail);
      check("grant_id", grant_id, exp_gid);
      check("tx_data", tx_data, exp_data);
      check("start_while_busy", tx_start & tx_busy, 0);
      hs_prev = req_ready & v;
      if (req_ready != '0) dut_acc_cyc = cyc;
      if (tx_start) begin
         dlog.push_back(int'(grant_id));
         dstart.push_back(cyc);
      end
      if (w >= 0) begin
         n_acc++;
         t0       = cyc;
         exp_gid  = w;
         exp_data = d[w];
         exp_ptr  = (w + 1) % N;
         avail    = (fl == 0) ? cyc + 4 : cyc + 3 + fd + fl;
         busy_lo  = cyc + 2 + fd;
         busy_hi  = cyc + 1 + fd + fl;
         if (mode == M_RAND) begin
            fl = $urandom_range(0, 12);
            fd = $urandom_range(0, 1);
         end
      end
      if (rst) begin
         avail    = cyc + 1;
         t0       = -100;
         exp_ptr  = 0;
         exp_gid  = 0;
         exp_data = '0;
      end
   endtask

   task automatic wait_accept(string tag, int bound);
      int n0 = n_acc;
      int k  = 0;
      while (n_acc == n0 && k < bound) begin
         step();
         k++;
      end
      if (n_acc == n0) check({tag, "_timeout"}, n_acc, n0 + 1);
   endtask

   task automatic wait_idle(string tag, int bound);
      int k = 0;
      while ((cyc < avail || cyc <= busy_hi || ext_left > 0) && k < bound) begin
         step();
         k++;
      end
      if (cyc < avail) check({tag, "_timeout"}, cyc, avail);
   endtask

   task automatic do_reset();
      rst_at = cyc + 1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, k, n0;
      rst = 1'b1; v = '0; hs_prev = '0; tx_busy = 1'b0;
      req_valid = '0; req_data = '0;
      for (int i = 0; i < N; i++) begin d[i] = '0; rem[i] = 0; end
      mode = M_HOLD; cyc = 0; rst_at = -1; ext_left = 0;
      busy_lo = 0; busy_hi = -1; fl = 8; fd = 0;
      t0 = -100; avail = 0; exp_ptr = 0; exp_gid = 0; exp_data = '0;
      n_acc = 0; dut_acc_cyc = -1;
      repeat (3) @(posedge clk);

      // single requester 2 with byte A5
      step();
      v[2] = 1'b1; d[2] = 8'hA5;
      wait_accept("A_accept", 10);
      check("A_ready", req_ready, 4'b0100);
      step();
      check("A_start", tx_start, 1);
      check("A_data", tx_data, 8'hA5);
      check("A_gid", grant_id, 2);
      wait_idle("A_idle", 40);

      // all four continuously valid, three frames each, 10-cycle busy
      do_reset();
      dlog.delete();
      mode = M_ALL; fl = 10; fd = 0;
      for (int i = 0; i < N; i++) rem[i] = 3;
      k = 0;
      while ((rem[0] + rem[1] + rem[2] + rem[3] > 0 || cyc < avail) && k < 400) begin
         step();
         k++;
      end
      mode = M_HOLD;
      wait_idle("B_idle", 40);
      check("B_count", dlog.size(), 12);
      for (int i = 0; i < dlog.size() && i < 12; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
         check("B_order", dlog[i], i / 3);
`else
         check("B_order", dlog[i], i % 4);
`endif
      end

      // transmitter never raises busy: timeout path back to IDLE
      fl = 0; fd = 0;
      n0 = dstart.size();
      v = 4'b1010; d[1] = 8'h3C; d[3] = 8'hC3;
      k = 0;
      while ((v != '0 || cyc < avail) && k < 60) begin
         step();
         k++;
      end
      check("C_starts", dstart.size() - n0, 2);
      if (dstart.size() - n0 >= 2) check("C_start_gap", dstart[n0+1] - dstart[n0], 4);

      // reset while waiting for the frame to finish
      fl = 10; fd = 0;
      v[1] = 1'b1; d[1] = 8'h5A;
      wait_accept("D_accept", 10);
      v = 4'b1001; d[0] = 8'h11; d[3] = 8'h33;
      rst_at = t0 + 5;
      s = rst_at;
      k = 0;
      while (cyc < s + 1 && k < 20) begin
         step();
         k++;
      end
      check("D_rst_outs", {req_ready, tx_start, tx_data, grant_id, grant_valid}, 0);
      n0 = dlog.size();
      k = 0;
      while (dlog.size() == n0 && k < 40) begin
         step();
         k++;
      end
      check("D_first_after_rst", (dlog.size() > n0) ? dlog[n0] : -1, 0);
      k = 0;
      while ((v != '0 || cyc < avail) && k < 60) begin
         step();
         k++;
      end
      wait_idle("D_idle", 40);

      // externally held busy blocks the grant until it drops
      ext_left = 5;
      v[1] = 1'b1; d[1] = 8'h77;
      s = cyc + 1;
      wait_accept("E_accept", 20);
      check("E_accept_cycle", dut_acc_cyc, s + 5);
      wait_idle("E_idle", 40);

      // randomized traffic
      mode = M_RAND;
      fl = $urandom_range(0, 12);
      fd = $urandom_range(0, 1);
      repeat (3000) step();
      mode = M_HOLD;
      v = '0;
      wait_idle("F_idle", 40);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmitter between `N_REQ` byte producers. It sits between the requesters' valid/ready byte streams and the single `uart_tx` datapath. It accepts one byte at a time, issues a one-cycle start strobe with the byte held stable, and tracks the transmitter's busy flag before granting the next requester.

## Interface
- `N_REQ`, 4, number of requesters; power of two, 2..8
- `DATA_W`, 8, byte width
- `ID_W`, `$clog2(N_REQ)`, grant index width; derived, not overridden

- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  N_REQ  per-requester byte valid
- `req_data`  in  N_REQ*DATA_W  requester i owns bits [i*DATA_W +: DATA_W]
- `req_ready`  out  N_REQ  one-hot accept; transfer when valid&ready at a rising edge
- `tx_data`  out  DATA_W  byte to transmitter, held from START until next grant
- `tx_start`  out  1  one-cycle start strobe
- `tx_busy`  in  1  transmitter busy, high for the duration of a frame
- `grant_id`  out  ID_W  index of the requester currently being served
- `grant_valid`  out  1  high from accept until the frame completes

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any `req_valid` and `!tx_busy`, pick winner w: first set `req_valid` bit searching upward from `ptr`, wrapping modulo N_REQ.
  - `req_ready[w]`=1, combinational in IDLE only; all other bits 0.
  - At the edge: `tx_data`<=data[w], `grant_id`<=w, `grant_valid`<=1, `ptr`<=(w+1) mod N_REQ, go to START.
- START: `tx_start`=1 (registered, exactly one cycle); go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_busy`=1 goes to WAIT_DONE.
  - If `tx_busy` is not seen within 2 cycles in this state, go to IDLE and clear `grant_valid`; the frame counts as complete.
- WAIT_DONE: `tx_busy`=0 goes to IDLE and clears `grant_valid`.
- `req_ready` is 0 in every state except IDLE. Requesters must hold `req_data` stable while `req_valid` is high.
- Only a requester's own valid&ready handshake retires its byte. Dropping `req_valid` before grant withdraws the request with no side effect.
- `tx_busy` already high in IDLE (transmitter owned elsewhere or still draining): no grant.

## Timing
- Reset values:
  - `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `grant_valid`=0.
  - `ptr`=0, state IDLE.
- Reset has priority over every transition. Reset mid-frame returns to IDLE immediately. The arbiter does not abort the transmitter; `uart_tx` has its own reset.
- Accept at edge T0 (ready high in cycle T0).
- `tx_start` high during cycle T0+1 only.
- `tx_busy` is expected from T0+2.
- Completion: `tx_busy` seen low in WAIT_DONE at edge Tk gives IDLE in cycle Tk+1. The next accept can occur at edge Tk+1 (ready high in the same cycle).
- Simultaneous requests: exactly one winner per grant, never two ready bits.
- Starvation bound: a continuously valid requester is served within N_REQ grants.
- `ptr` wrap: after w=N_REQ-1, search restarts at 0.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest-index valid requester always wins, `ptr` is held at 0, and the starvation bound does not apply.
  - Undefined (default): round-robin as above.
- No other behaviour differs between the two builds.

## Test plan
- Single requester 2 presents 8'hA5 with idle transmitter:
  - `req_ready`=4'b0100 in the same cycle, `tx_start` one cycle later with `tx_data`=8'hA5.
  - `grant_id`=2 until the busy fall.
- All four valid continuously, 3 frames each, transmitter model busy 10 cycles per frame:
  - Grant order 0,1,2,3,0,1,2,3,…
  - Never two `req_ready` bits high; `tx_start` never while `tx_busy`=1.
- Same stimulus with `UART_ARB_FIXED_PRIO_EN` defined: requester 0 served 3 times first, then 1, then 2, then 3.
- Transmitter model never raises `tx_busy`: arbiter returns to IDLE 3 cycles after `tx_start` and grants the next requester.
- Assert `rst` for one cycle while in WAIT_DONE:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - After release the first grant goes to the lowest-index valid requester (`ptr`=0).
- `tx_busy` held high externally with requester 1 valid: `req_ready` stays 0. Drop `tx_busy`: requester 1 is accepted in that same cycle.
